// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// NREQ requesters. It captures the winner's byte and frame configuration,
// launches the frame with a one-cycle tx_enable pulse, and holds the Tx inputs
// stable until the next capture. After each frame it pulses the owner's done
// bit and inserts an optional idle gap.
//
// Ports:
//   bd_rate_tx  baud-rate clock (shared with Tx)
//   reset       synchronous, active-high reset
//   req         per-requester request level
//   req_data    byte i in bits [8i+7:8i]
//   req_d_num   1 = 8 data bits, 0 = 7 data bits
//   req_par     parity mode i in bits [2i+1:2i] (11 is reserved, sent as 00)
//   gnt         one-cycle capture pulse, one-hot
//   done        one-cycle frame-complete pulse, one-hot
//   busy        high from capture until the end of the gap
//   owner       index of the current or last granted requester
//   tx_enable   one-cycle frame launch to Tx
//   tx_data     byte to Tx
//   tx_d_num    data-bit count select to Tx
//   tx_par      parity mode to Tx
module uart_tx_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                 bd_rate_tx,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [8*NREQ-1:0]    req_data,
   input  logic [NREQ-1:0]      req_d_num,
   input  logic [2*NREQ-1:0]    req_par,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [2:0]           owner,
   output logic                 tx_enable,
   output logic [7:0]           tx_data,
   output logic                 tx_d_num,
   output logic [1:0]           tx_par
);

   // Counter must hold the longest frame load (9) or the gap reload.
   localparam int unsigned CNT_MAX = (GAP_CYCLES > 9) ? GAP_CYCLES : 9;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [NREQ-1:0]     done_q, done_d;
   logic                busy_q, busy_d;
   logic [2:0]          owner_q, owner_d;
   logic                tx_enable_q, tx_enable_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_d_num_q, tx_d_num_d;
   logic [1:0]          tx_par_q, tx_par_d;

   logic [NREQ-1:0]     rot_req;
   logic                win_found;
   logic [2:0]          win_off;
   logic [3:0]          win_sum;
   logic [2:0]          win_idx;
   logic [7:0]          sel_data;
   logic                sel_d_num;
   logic [1:0]          sel_par;

   // Rotate requests so that bit 0 is the requester the pointer points at.
   assign rot_req = NREQ'({req, req} >> ptr_q);

   // Round-robin winner: first set bit at or above the pointer, with wrap.
   always_comb begin
      win_found = 1'b0;
      win_off   = 3'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && rot_req[i]) begin
            win_found = 1'b1;
            win_off   = 3'(i);
         end
      end
      win_sum = {1'b0, ptr_q} + {1'b0, win_off};
      win_idx = (win_sum >= 4'(NREQ)) ? 3'(win_sum - 4'(NREQ)) : 3'(win_sum);
   end

   // Winner's payload mux.
   always_comb begin
      sel_data  = 8'd0;
      sel_d_num = 1'b0;
      sel_par   = 2'b00;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == 3'(i)) begin
            sel_data  = req_data[8*i +: 8];
            sel_d_num = req_d_num[i];
            sel_par   = req_par[2*i +: 2];
         end
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      gnt_d       = '0;
      done_d      = '0;
      busy_d      = busy_q;
      owner_d     = owner_q;
      tx_enable_d = 1'b0;
      tx_data_d   = tx_data_q;
      tx_d_num_d  = tx_d_num_q;
      tx_par_d    = tx_par_q;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               for (int i = 0; i < NREQ; i++) begin
                  gnt_d[i] = (win_idx == 3'(i));
               end
               owner_d     = win_idx;
               busy_d      = 1'b1;
               tx_enable_d = 1'b1;
               tx_data_d   = sel_data;
               tx_d_num_d  = sel_d_num;
               tx_par_d    = (sel_par == 2'b11) ? 2'b00 : sel_par;
               ptr_d       = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
               state_d     = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            // Data bits plus one; enable cycle + BUSY spans bits+3 cycles.
            cnt_d   = tx_d_num_q ? CNT_W'(9) : CNT_W'(8);
            state_d = S_BUSY;
         end

         S_BUSY: begin
            if (cnt_q == '0) begin
               for (int i = 0; i < NREQ; i++) begin
                  done_d[i] = (owner_q == 3'(i));
               end
               if (GAP_CYCLES == 0) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = CNT_W'(GAP_CYCLES - 1);
                  state_d = S_GAP;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_GAP: begin
            if (cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge bd_rate_tx) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ptr_q       <= 3'd0;
         gnt_q       <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         owner_q     <= 3'd0;
         tx_enable_q <= 1'b0;
         tx_data_q   <= 8'd0;
         tx_d_num_q  <= 1'b0;
         tx_par_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         owner_q     <= owner_d;
         tx_enable_q <= tx_enable_d;
         tx_data_q   <= tx_data_d;
         tx_d_num_q  <= tx_d_num_d;
         tx_par_q    <= tx_par_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign owner     = owner_q;
   assign tx_enable = tx_enable_q;
   assign tx_data   = tx_data_q;
   assign tx_d_num  = tx_d_num_q;
   assign tx_par    = tx_par_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a default instance (GAP_CYCLES=2) checked by a
// grant/done scoreboard, plus a GAP_CYCLES=0 instance for back-to-back grants.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        reset;

   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_d_num;
   logic [7:0]  req_par;
   logic [3:0]  gnt, done;
   logic        busy, tx_enable, tx_d_num;
   logic [2:0]  owner;
   logic [7:0]  tx_data;
   logic [1:0]  tx_par;

   logic [3:0]  req_z;
   logic [31:0] req_data_z;
   logic [3:0]  req_d_num_z;
   logic [7:0]  req_par_z;
   logic [3:0]  gnt_z, done_z;
   logic        busy_z, tx_enable_z, tx_d_num_z;
   logic [2:0]  owner_z;
   logic [7:0]  tx_data_z;
   logic [1:0]  tx_par_z;

   uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(2)) u_dut (
      .bd_rate_tx (clk),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .req_d_num  (req_d_num),
      .req_par    (req_par),
      .gnt        (gnt),
      .done       (done),
      .busy       (busy),
      .owner      (owner),
      .tx_enable  (tx_enable),
      .tx_data    (tx_data),
      .tx_d_num   (tx_d_num),
      .tx_par     (tx_par)
   );

   uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0)) u_dut_nogap (
      .bd_rate_tx (clk),
      .reset      (reset),
      .req        (req_z),
      .req_data   (req_data_z),
      .req_d_num  (req_d_num_z),
      .req_par    (req_par_z),
      .gnt        (gnt_z),
      .done       (done_z),
      .busy       (busy_z),
      .owner      (owner_z),
      .tx_enable  (tx_enable_z),
      .tx_data    (tx_data_z),
      .tx_d_num   (tx_d_num_z),
      .tx_par     (tx_par_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       dnum;
      logic [1:0] par;
   } exp_t;

   exp_t exp_g[$];
   int   d_idx[$];
   int   d_due[$];

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_done_cyc = 0;
   int   busy_fall_cyc = 0;
   logic prev_busy = 1'b0;
   logic auto_drop = 1'b1;
   logic [7:0] cur_data = 8'd0;
   logic       cur_dnum = 1'b0;
   logic [1:0] cur_par  = 2'b00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int idx, input logic [7:0] data, input logic dnum, input logic [1:0] par);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      e.dnum = dnum;
      e.par  = (par == 2'b11) ? 2'b00 : par;
      exp_g.push_back(e);
   endtask

   task automatic set_req(input int i, input logic [7:0] data, input logic dnum, input logic [1:0] par);
      req_data[8*i +: 8] = data;
      req_d_num[i]       = dnum;
      req_par[2*i +: 2]  = par;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},  32'(gnt), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_owner"}, 32'(owner), 0);
      chk({tag, "_tx_en"}, 32'(tx_enable), 0);
      chk({tag, "_tx_cfg"}, 32'({tx_data, tx_d_num, tx_par}), 0);
   endtask

   // One clock with sampling 1 time unit after the edge, plus scoreboard monitor.
   task automatic step();
      logic rst_at_edge;
      exp_t e;
      int   di, dd;
      rst_at_edge = reset;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_at_edge) begin
         cur_data  = 8'd0;
         cur_dnum  = 1'b0;
         cur_par   = 2'b00;
         prev_busy = 1'b0;
         return;
      end
      if (gnt !== 4'd0) begin
         if (exp_g.size() == 0) begin
            chk("unexpected_gnt", 32'(gnt), 0);
         end else begin
            e = exp_g.pop_front();
            chk("gnt_vec", 32'(gnt), 32'(1) << e.idx);
            chk("owner", 32'(owner), 32'(e.idx));
            chk("tx_data", 32'(tx_data), 32'(e.data));
            chk("tx_d_num", 32'(tx_d_num), 32'(e.dnum));
            chk("tx_par", 32'(tx_par), 32'(e.par));
            chk("tx_enable", 32'(tx_enable), 1);
            chk("gnt_while_busy", 32'(prev_busy), 0);
            cur_data = e.data;
            cur_dnum = e.dnum;
            cur_par  = e.par;
            d_idx.push_back(e.idx);
            d_due.push_back(cyc + (e.dnum ? 11 : 10));
            if (auto_drop) req[e.idx] = 1'b0;
         end
      end else begin
         chk("tx_enable_idle", 32'(tx_enable), 0);
         chk("tx_hold", 32'({tx_data, tx_d_num, tx_par}), 32'({cur_data, cur_dnum, cur_par}));
      end
      if (done !== 4'd0) begin
         if (d_idx.size() == 0) begin
            chk("unexpected_done", 32'(done), 0);
         end else begin
            di = d_idx.pop_front();
            dd = d_due.pop_front();
            chk("done_vec", 32'(done), 32'(1) << di);
            chk("done_cycle", 32'(cyc), 32'(dd));
            last_done_cyc = cyc;
         end
      end else if (d_due.size() != 0 && cyc > d_due[0]) begin
         chk("done_missing", 32'(cyc), 32'(d_due[0]));
         di = d_idx.pop_front();
         dd = d_due.pop_front();
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      prev_busy = busy;
   endtask

   task automatic run_quiet(input int budget);
      int n;
      n = 0;
      while ((exp_g.size() != 0 || d_idx.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      if (exp_g.size() != 0 || d_idx.size() != 0 || busy)
         chk("timeout_quiet", 32'(n), 32'(budget + 1));
   endtask

   task automatic run_grants(input int budget);
      int n;
      n = 0;
      while (exp_g.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_g.size() != 0) chk("timeout_grants", 32'(exp_g.size()), 0);
   endtask

   initial begin
      int c0;
      int n;
      reset       = 1'b1;
      req         = 4'd0;
      req_data    = 32'd0;
      req_d_num   = 4'd0;
      req_par     = 8'd0;
      req_z       = 4'd0;
      req_data_z  = 32'd0;
      req_d_num_z = 4'd0;
      req_par_z   = 8'd0;

      // Reset state
      repeat (3) step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();

      // Single 8-bit frame, even parity
      set_req(2, 8'hA5, 1'b1, 2'b01);
      req[2] = 1'b1;
      push_exp(2, 8'hA5, 1'b1, 2'b01);
      step();
      chk("t1_gnt_latency", 32'(gnt), 32'h4);
      run_quiet(60);
      chk("t1_busy_fall", 32'(busy_fall_cyc - last_done_cyc), 2);

      // 7-bit frame; pointer at 3 wraps to requester 0
      set_req(0, 8'h3C, 1'b0, 2'b10);
      req[0] = 1'b1;
      push_exp(0, 8'h3C, 1'b0, 2'b10);
      run_quiet(60);
      chk("t2_tx_d_num_final", 32'(tx_d_num), 0);

      // Reset from idle returns the pointer to 0
      reset = 1'b1;
      step();
      chk_all_zero("reset_idle");
      reset = 1'b0;

      // Round-robin with all requesters held; requester 3 uses reserved parity
      for (int i = 0; i < 4; i++) set_req(i, 8'h10 + 8'(i), 1'b1, 2'(i));
      auto_drop = 1'b0;
      req = 4'hF;
      for (int i = 0; i < 4; i++) push_exp(i, 8'h10 + 8'(i), 1'b1, 2'(i));
      push_exp(0, 8'h10, 1'b1, 2'b00);
      run_grants(300);
      req = 4'd0;
      auto_drop = 1'b1;
      run_quiet(100);

      // Pointer wrap: grant 3, then 1001 grants 0 then 3
      req = 4'b1000;
      push_exp(3, 8'h13, 1'b1, 2'b11);
      run_quiet(60);
      auto_drop = 1'b0;
      req = 4'b1001;
      push_exp(0, 8'h10, 1'b1, 2'b00);
      push_exp(3, 8'h13, 1'b1, 2'b11);
      run_grants(100);
      req = 4'd0;
      auto_drop = 1'b1;
      run_quiet(60);

      // Zero-gap instance: reserved parity forced to 00, back-to-back grant
      req_data_z[7:0]  = 8'hC3;
      req_d_num_z[0]   = 1'b1;
      req_par_z[1:0]   = 2'b11;
      req_data_z[15:8] = 8'h5A;
      req_d_num_z[1]   = 1'b1;
      req_par_z[3:2]   = 2'b10;
      req_z = 4'b0011;
      step();
      c0 = cyc;
      chk("t5_gnt0", 32'(gnt_z), 32'h1);
      chk("t5_par_forced", 32'(tx_par_z), 0);
      chk("t5_data", 32'(tx_data_z), 32'hC3);
      req_z[0] = 1'b0;
      n = 0;
      while (done_z === 4'd0 && n < 40) begin
         step();
         n++;
      end
      chk("t5_done_cycle", 32'(cyc - c0), 11);
      chk("t5_done_vec", 32'(done_z), 32'h1);
      chk("t5_busy_at_done", 32'(busy_z), 0);
      step();
      chk("t5_gnt1", 32'(gnt_z), 32'h2);
      chk("t5_par10", 32'(tx_par_z), 32'h2);
      chk("t5_data1", 32'(tx_data_z), 32'h5A);
      req_z = 4'd0;
      n = 0;
      while (busy_z === 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("t5_idle", 32'(busy_z), 0);

      // Reset mid-frame: everything clears and no done pulse follows
      set_req(0, 8'h77, 1'b1, 2'b01);
      req[0] = 1'b1;
      push_exp(0, 8'h77, 1'b1, 2'b01);
      step();
      chk("t6_gnt0", 32'(gnt), 32'h1);
      repeat (4) step();
      reset = 1'b1;
      step();
      chk_all_zero("t6_reset");
      d_idx.delete();
      d_due.delete();
      reset = 1'b0;
      repeat (15) step();
      set_req(1, 8'h5A, 1'b0, 2'b01);
      req[1] = 1'b1;
      push_exp(1, 8'h5A, 1'b0, 2'b01);
      step();
      chk("t6_gnt1", 32'(gnt), 32'h2);
      run_quiet(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
